// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
// The helpers work on a fixed 32-bit width, so callers zero-extend the input and truncate the result.
package gray_pkg;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the low bits unaffected
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_param_gray2bin_comb.sv
// Combinational N-bit Gray-to-binary converter.
// Used by logic that receives a synchronised Gray pointer on the far side of a clock crossing.
module gray2bin_comb
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  assign o_bin = N'(gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised Gray counter with enable, up/down, load, clear and wrap/saturate control.
// The binary and Gray registers load from the same next value, so the Gray output is taken straight from a flop.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int N         = 4,
  parameter int SATURATE  = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_en,
  input  logic         i_up_dn,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  output logic [N-1:0] o_gray_count,
  output logic [N-1:0] o_bin_count,
  output logic         o_wrap,
  output logic         o_at_max,
  output logic         o_at_min
);

  localparam logic [N-1:0] MAX_VAL  = '1;
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] RST_BIN  = N'(RESET_VAL);
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(GRAY_MAX_W'(RESET_VAL)));
  localparam bit           SAT_EN   = (SATURATE == MODE_SAT);

  logic [N-1:0] r_bin;
  logic [N-1:0] r_gray;
  logic         r_wrap;

  logic [N-1:0] w_bin_next;
  logic [N-1:0] w_gray_next;
  logic         w_wrap_next;

  // Priority: clear, then load, then count; a limit step either wraps (pulsing o_wrap) or holds
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (i_clr) begin
      w_bin_next = '0;
    end else if (i_load) begin
      w_bin_next = i_load_val;
    end else if (i_en) begin
      if (i_up_dn) begin
        if (r_bin != MAX_VAL) begin
          w_bin_next = r_bin + ONE;
        end else if (!SAT_EN) begin
          w_bin_next  = '0;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (r_bin != '0) begin
          w_bin_next = r_bin - ONE;
        end else if (!SAT_EN) begin
          w_bin_next  = MAX_VAL;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  assign w_gray_next = N'(bin2gray(GRAY_MAX_W'(w_bin_next)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_gray_count = r_gray;
  assign o_bin_count  = r_bin;
  assign o_wrap       = r_wrap;
  assign o_at_max     = (r_bin == MAX_VAL);
  assign o_at_min     = (r_bin == '0);

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed and randomised checks of gray_counter_param: 4-bit wrap/saturate/reset-value
// instances share one stimulus set, and 8-bit wrap/saturate instances run against a reference model.
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en4, up4, clr4, load4;
  logic [3:0] lv4;
  logic       en8, up8, clr8, load8;
  logic [7:0] lv8;

  logic [3:0] gW, bW, gS, bS, gR, bR;
  logic       wW, mxW, mnW, wS, mxS, mnS, wR, mxR, mnR;
  logic [7:0] g8W, b8W, g8S, b8S;
  logic       w8W, mx8W, mn8W, w8S, mx8S, mn8S;

  int nChecks = 0;
  int nErrors = 0;

  logic [3:0] grayUp [0:16];

  gray_counter_param #(.N(4), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en4), .i_up_dn(up4), .i_clr(clr4),
    .i_load(load4), .i_load_val(lv4), .o_gray_count(gW), .o_bin_count(bW),
    .o_wrap(wW), .o_at_max(mxW), .o_at_min(mnW));

  gray_counter_param #(.N(4), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en4), .i_up_dn(up4), .i_clr(clr4),
    .i_load(load4), .i_load_val(lv4), .o_gray_count(gS), .o_bin_count(bS),
    .o_wrap(wS), .o_at_max(mxS), .o_at_min(mnS));

  gray_counter_param #(.N(4), .SATURATE(0), .RESET_VAL(5)) u_rv5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en4), .i_up_dn(up4), .i_clr(clr4),
    .i_load(load4), .i_load_val(lv4), .o_gray_count(gR), .o_bin_count(bR),
    .o_wrap(wR), .o_at_max(mxR), .o_at_min(mnR));

  gray_counter_param #(.N(8), .SATURATE(0), .RESET_VAL(0)) u_rnd_wrap (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en8), .i_up_dn(up8), .i_clr(clr8),
    .i_load(load8), .i_load_val(lv8), .o_gray_count(g8W), .o_bin_count(b8W),
    .o_wrap(w8W), .o_at_max(mx8W), .o_at_min(mn8W));

  gray_counter_param #(.N(8), .SATURATE(1), .RESET_VAL(0)) u_rnd_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en8), .i_up_dn(up8), .i_clr(clr8),
    .i_load(load8), .i_load_val(lv8), .o_gray_count(g8S), .o_bin_count(b8S),
    .o_wrap(w8S), .o_at_max(mx8S), .o_at_min(mn8S));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] g, b, input logic w,
                            input logic [3:0] eg, eb, input logic ew);
    checkOutput({tag, " gray"}, g, eg);
    checkOutput({tag, " bin"}, b, eb);
    checkOutput({tag, " wrap"}, w, ew);
  endtask

  task automatic applyStimulus(input logic clr, load, en, up, input logic [3:0] lv);
    clr4  = clr;
    load4 = load;
    en4   = en;
    up4   = up;
    lv4   = lv;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tbGray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic void stepModel(input int b, input bit sat, input bit clr, load, en, up,
                                    input int lv, input int maxv, output int nb, output bit w);
    nb = b;
    w  = 1'b0;
    if (clr) nb = 0;
    else if (load) nb = lv;
    else if (en) begin
      if (up) begin
        if (b != maxv) nb = b + 1;
        else if (!sat) begin nb = 0; w = 1'b1; end
      end else begin
        if (b != 0) nb = b - 1;
        else if (!sat) begin nb = maxv; w = 1'b1; end
      end
    end
  endfunction

  task automatic checkRand(input string tag, input logic [7:0] g, b, input logic w, mx, mn,
                           input int m, input bit ew, input bit counted, input logic [7:0] pg);
    logic [7:0] em;
    em = m[7:0];
    checkOutput({tag, " bin"}, b, em);
    checkOutput({tag, " gray"}, g, em ^ (em >> 1));
    checkOutput({tag, " wrap"}, w, ew);
    checkOutput({tag, " max"}, mx, em == 8'hFF);
    checkOutput({tag, " min"}, mn, em == 8'h00);
    checkOutput({tag, " g2b"}, tbGray2bin(g), em);
    if (counted) checkOutput({tag, " onebit"}, $countones(g ^ pg), 1);
  endtask

  initial begin
    logic [3:0] prevG;
    int mW, mS, nW, nS, r;
    bit ewW, ewS, dir, cntW, cntS;
    logic [7:0] pgW, pgS;

    grayUp = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst_n = 1'b0;
    {clr4, load4, en4, up4} = '0;
    lv4 = '0;
    {clr8, load8, en8, up8} = '0;
    lv8 = '0;

    #12;
    checkState("reset wrap", gW, bW, wW, 4'h0, 4'h0, 1'b0);
    checkOutput("reset at_min", mnW, 1'b1);
    checkOutput("reset at_max", mxW, 1'b0);
    checkState("reset rv5", gR, bR, wR, 4'h7, 4'h5, 1'b0);
    rst_n = 1'b1;

    // Full up sequence, wrapping once on the 16th edge; the saturating copy stops at 15
    prevG = gW;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      checkState($sformatf("up%0d", k), gW, bW, wW, grayUp[k], 4'(k % 16), k == 16);
      checkOutput($sformatf("up%0d onebit", k), $countones(gW ^ prevG), 1);
      checkOutput($sformatf("up%0d at_max", k), mxW, k == 15);
      checkState($sformatf("satup%0d", k), gS, bS, wS, grayUp[k < 15 ? k : 15], 4'(k < 15 ? k : 15), 1'b0);
      prevG = gW;
    end
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      checkState($sformatf("sathold%0d", j), gS, bS, wS, 4'h8, 4'hF, 1'b0);
      checkOutput($sformatf("sathold%0d at_max", j), mxS, 1'b1);
      checkState($sformatf("upagain%0d", j), gW, bW, wW, grayUp[j], 4'(j), 1'b0);
    end

    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      checkState($sformatf("satdn%0d", k), gS, bS, wS, grayUp[k < 15 ? 15 - k : 0], 4'(k < 15 ? 15 - k : 0), 1'b0);
    end
    checkOutput("satdn at_min", mnS, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    checkState("clr", gW, bW, wW, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkState("dnwrap", gW, bW, wW, 4'h8, 4'hF, 1'b1);
    checkOutput("dnwrap at_max", mxW, 1'b1);
    checkOutput("dnwrap at_min", mnW, 1'b0);
    checkState("satdn0", gS, bS, wS, 4'h0, 4'h0, 1'b0);

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    checkState("midcount", gW, bW, wW, 4'h3, 4'h2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    checkState("load", gW, bW, wW, 4'hF, 4'hA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
    checkState("lvignored", gW, bW, wW, 4'hF, 4'hA, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
    checkState("clrwins", gW, bW, wW, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
    checkState("load6", gW, bW, wW, 4'h5, 4'h6, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
      checkState($sformatf("hold%0d", k), gW, bW, wW, 4'h5, 4'h6, 1'b0);
    end

    // Asynchronous reset between edges while counting at 7
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    checkState("at7", gW, bW, wW, 4'h4, 4'h7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkState("asyncrst wrap", gW, bW, wW, 4'h0, 4'h0, 1'b0);
    checkState("asyncrst rv5", gR, bR, wR, 4'h7, 4'h5, 1'b0);
    @(posedge clk);
    #1;
    checkState("inreset rv5", gR, bR, wR, 4'h7, 4'h5, 1'b0);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    checkState("release wrap", gW, bW, wW, 4'h1, 4'h1, 1'b0);
    checkState("release rv5", gR, bR, wR, 4'h5, 4'h6, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Randomised 8-bit phase against the reference model
    clr8 = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
    mW = 0;
    mS = 0;
    pgW = g8W;
    pgS = g8S;
    checkOutput("rnd start bin", b8W, 8'h00);
    dir = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      r = int'($urandom_range(0, 63));
      clr8  = (r == 0);
      load8 = (r >= 1 && r <= 3);
      en8   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) dir = ~dir;
      up8 = ($urandom_range(0, 7) != 0) ? dir : ~dir;
      case ($urandom_range(0, 3))
        0: lv8 = 8'h00;
        1: lv8 = 8'hFF;
        default: lv8 = 8'($urandom_range(0, 255));
      endcase
      stepModel(mW, 1'b0, clr8, load8, en8, up8, int'(lv8), 255, nW, ewW);
      stepModel(mS, 1'b1, clr8, load8, en8, up8, int'(lv8), 255, nS, ewS);
      cntW = !clr8 && !load8 && en8 && (nW != mW);
      cntS = !clr8 && !load8 && en8 && (nS != mS);
      @(posedge clk);
      #1;
      checkRand("rndwrap", g8W, b8W, w8W, mx8W, mn8W, nW, ewW, cntW, pgW);
      checkRand("rndsat", g8S, b8S, w8S, mx8S, mn8S, nS, ewS, cntS, pgS);
      mW = nW;
      mS = nS;
      pgW = g8W;
      pgS = g8S;
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised, next-generation Gray-code counter. Adds to the plain free-running Gray counter: width generic, enable, up/down, binary load, synchronous clear, wrap/saturate mode, binary mirror output and boundary flags.
- Used as a pointer and sequence source for clock-domain-crossing logic (async FIFO pointers, multi-bit status sync). The Gray output must be a direct flop output with a one-bit change per step.

Parameters:
- N, 4, counter width in bits (N >= 2).
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.
- RESET_VAL, 0, binary count value loaded on reset (< 2^N).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_en  in  1  count enable.
- i_up_dn  in  1  1 = count up, 0 = count down.
- i_clr  in  1  synchronous clear to binary 0.
- i_load  in  1  synchronous load.
- i_load_val  in  N  binary value for load.
- o_gray_count  out  N  Gray count, registered.
- o_bin_count  out  N  binary equivalent, registered.
- o_wrap  out  1  one-cycle pulse: last step wrapped.
- o_at_max  out  1  o_bin_count == 2^N-1.
- o_at_min  out  1  o_bin_count == 0.

Behaviour:
- State: binary register B and Gray register G, both N bits.
  - G always equals bin2gray(B).
  - Both registers update in the same edge from the same next-state value, so o_gray_count is never decoded combinationally.
- Reset (i_reset_n low, asynchronous):
  - B = RESET_VAL; G = bin2gray(RESET_VAL); o_wrap = 0.
  - Flags follow B.
  - Release is synchronous in effect: the first count happens on the first rising edge with i_reset_n high.
- Per-edge priority: i_clr > i_load > i_en > hold.
  - i_clr: B <= 0, o_wrap <= 0.
  - i_load: B <= i_load_val, o_wrap <= 0.
  - i_en, up, B < 2^N-1: B <= B+1.
  - i_en, down, B > 0: B <= B-1.
  - i_en, up, B = 2^N-1:
    - SATURATE=0: B <= 0, o_wrap <= 1.
    - SATURATE=1: hold, o_wrap <= 0.
  - i_en, down, B = 0:
    - SATURATE=0: B <= 2^N-1, o_wrap <= 1.
    - SATURATE=1: hold, o_wrap <= 0.
  - Otherwise: hold, o_wrap <= 0.
- Latency: every command is visible on the outputs exactly one edge later.
- o_wrap is registered and high for exactly one cycle per wrap event.
- Flags o_at_max and o_at_min are combinational decodes of B (glitch-tolerant consumers only).
- Arithmetic is modulo 2^N, with no extra carry bit kept.
- Counting steps (not clear/load) change exactly one bit of o_gray_count, including across the wrap.
- i_up_dn may change on any cycle; the direction is sampled on the same edge as i_en.
- i_load_val is ignored unless i_load is high.
- Simultaneous i_clr and i_load: clear wins.

Decomposition:
- Package gray_pkg:
  - function bin2gray(b) = b ^ (b >> 1).
  - function gray2bin(g): prefix-XOR from the MSB.
  - localparams MODE_WRAP = 0 and MODE_SAT = 1.
- Optional sub-module gray2bin_comb (N-bit combinational converter), for consumers on the far side of a CDC. The counter itself needs no sub-module: it keeps B and uses bin2gray only.

Test Plan (N=4 unless noted):
- Reset, then i_en=1, i_up_dn=1 for 16 edges:
  - o_gray_count = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - o_wrap pulses only on the 1000->0000 step.
  - Each step changes exactly one bit.
- From B=0, i_up_dn=0, i_en=1:
  - Next edge gives o_gray_count=1000, o_bin_count=1111, o_wrap=1, o_at_max=1.
- SATURATE=1, count up to 15, keep i_en=1 for 3 more edges:
  - o_gray_count stays 1000 and o_wrap stays 0.
  - Count down to 0, hold 3 edges: o_gray_count stays 0000.
- i_load=1, i_load_val=1010 mid-count:
  - Next edge gives o_gray_count=1111, o_bin_count=1010.
  - Assert i_clr and i_load together: next edge gives 0000.
  - With i_en=0, outputs hold for 5 edges.
- Assert i_reset_n low between clock edges while counting at B=7:
  - Outputs go to RESET_VAL immediately, without an edge.
  - Repeat with RESET_VAL=5: o_gray_count=0111 during reset.
- Random stimulus, N=8, 10k cycles:
  - gray2bin(o_gray_count) == o_bin_count on every cycle.
  - Single-bit change on every counting step.
  - Reference-model match for wrap and saturate.
